// File: rtl/ama_riscv_decode_ctrl.sv
// Decode-stage control: registers the fetched instruction, classifies its immediate
// format, inserts bubbles on flush/invalid input and counts stalled cycles.
module ama_riscv_decode_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_in,
  input  logic        inst_valid_in,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] inst_out,
  output logic        inst_valid_out,
  output logic [3:0]  ig_sel,
  output logic        ig_en,
  output logic [24:0] ig_in,
  output logic        illegal,
  output logic [7:0]  stall_cnt,
  output logic        init_done
);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [3:0]  SEL_NONE = 4'd0;
  localparam logic [3:0]  SEL_I    = 4'd1;
  localparam logic [3:0]  SEL_S    = 4'd2;
  localparam logic [3:0]  SEL_B    = 4'd3;
  localparam logic [3:0]  SEL_J    = 4'd4;
  localparam logic [3:0]  SEL_U    = 4'd5;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [1:0]  INIT_LAST = 2'd2;

  state_t      state_reg, state_next;
  logic [1:0]  init_cnt_reg, init_cnt_next;
  logic [31:0] inst_reg, inst_next;
  logic        valid_reg, valid_next;
  logic [3:0]  sel_reg, sel_next;
  logic        en_reg, en_next;
  logic        illegal_reg, illegal_next;
  logic [7:0]  stall_cnt_reg, stall_cnt_next;
  logic        init_done_reg, init_done_next;

  logic [3:0]  dec_sel;
  logic        dec_illegal;

  // Opcode classification of the incoming instruction
  always_comb begin
    dec_sel     = SEL_NONE;
    dec_illegal = 1'b0;
    case (inst_in[6:0])
      7'b0000011, 7'b0010011,
      7'b1100111, 7'b1110011: dec_sel = SEL_I;
      7'b0100011:             dec_sel = SEL_S;
      7'b1100011:             dec_sel = SEL_B;
      7'b1101111:             dec_sel = SEL_J;
      7'b0110111, 7'b0010111: dec_sel = SEL_U;
      7'b0110011:             dec_sel = SEL_NONE;
      default:                dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    init_cnt_next  = init_cnt_reg;
    inst_next      = inst_reg;
    valid_next     = valid_reg;
    sel_next       = sel_reg;
    en_next        = en_reg;
    illegal_next   = illegal_reg;
    stall_cnt_next = stall_cnt_reg;
    init_done_next = init_done_reg;

    case (state_reg)
      INIT: begin
        // Registers already hold a bubble from reset; only the counter moves
        if (init_cnt_reg == INIT_LAST) begin
          state_next     = RUN;
          init_done_next = 1'b1;
        end else begin
          init_cnt_next = init_cnt_reg + 2'd1;
        end
      end
      RUN, HOLD: begin
        if (flush) begin
          state_next   = RUN;
          inst_next    = NOP;
          valid_next   = 1'b0;
          sel_next     = SEL_NONE;
          en_next      = 1'b0;
          illegal_next = 1'b0;
        end else if (stall) begin
          state_next = HOLD;
          if (stall_cnt_reg != 8'hFF) begin
            stall_cnt_next = stall_cnt_reg + 8'd1;
          end
        end else begin
          state_next = RUN;
          if (inst_valid_in) begin
            inst_next    = inst_in;
            valid_next   = 1'b1;
            sel_next     = dec_sel;
            en_next      = (dec_sel != SEL_NONE);
            illegal_next = dec_illegal;
          end else begin
            inst_next    = NOP;
            valid_next   = 1'b0;
            sel_next     = SEL_NONE;
            en_next      = 1'b0;
            illegal_next = 1'b0;
          end
        end
      end
      default: begin
        state_next    = INIT;
        init_cnt_next = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= INIT;
      init_cnt_reg  <= 2'd0;
      inst_reg      <= NOP;
      valid_reg     <= 1'b0;
      sel_reg       <= SEL_NONE;
      en_reg        <= 1'b0;
      illegal_reg   <= 1'b0;
      stall_cnt_reg <= 8'd0;
      init_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      init_cnt_reg  <= init_cnt_next;
      inst_reg      <= inst_next;
      valid_reg     <= valid_next;
      sel_reg       <= sel_next;
      en_reg        <= en_next;
      illegal_reg   <= illegal_next;
      stall_cnt_reg <= stall_cnt_next;
      init_done_reg <= init_done_next;
    end
  end

  assign inst_out       = inst_reg;
  assign inst_valid_out = valid_reg;
  assign ig_sel         = sel_reg;
  assign ig_en          = en_reg;
  assign ig_in          = inst_reg[31:7];
  assign illegal        = illegal_reg;
  assign stall_cnt      = stall_cnt_reg;
  assign init_done      = init_done_reg;

  // Unreachable-state and saturating-counter invariants for simulation only are
  // intentionally left to the bench; the encoding above already recovers to INIT.
  localparam logic [3:0] SEL_MAX = SEL_U;
  logic sel_in_range;
  assign sel_in_range = (sel_reg <= SEL_MAX);
  logic unused_ok;
  assign unused_ok = sel_in_range & (SEL_I != SEL_S) & (SEL_B != SEL_J);

endmodule

// File: doc/ama_riscv_decode_ctrl.md
AMA_RISCV_DECODE_CTRL -- requirements
Module: ama_riscv_decode_ctrl

Interface
REQ-001 SHALL have one clock and synchronous, active-high reset; the clock is named clk and the reset is named rst.
REQ-002 SHALL have these ports:
- clk  in  1  clock
- rst  in  1  sync active-high reset
- inst_in  in  32  fetched instruction
- inst_valid_in  in  1  inst_in is valid this cycle
- stall  in  1  hold decode register
- flush  in  1  kill decode register contents (taken branch/jump)
- inst_out  out  32  registered instruction
- inst_valid_out  out  1  inst_out is a real instruction
- ig_sel  out  4  immediate-format select to the immediate generator
- ig_en  out  1  immediate generator enable
- ig_in  out  25  inst_out[31:7], wired to the immediate generator input
- illegal  out  1  opcode of inst_out is not recognised
- stall_cnt  out  8  saturating count of stalled cycles since reset
- init_done  out  1  start-up sequence complete
REQ-003 SHALL use these ig_sel codes: NONE 4'd0, I 4'd1, S 4'd2, B 4'd3, J 4'd4, U 4'd5.

Function
REQ-004 SHALL register inst_in, inst_valid_in and the decode result with 1-cycle latency; all outputs come from registers except ig_in.
REQ-005 SHALL decode inst_in[6:0] as follows; valid opcodes set illegal=0:
- 0000011, 0010011, 1100111, 1110011 -> I
- 0100011 -> S
- 1100011 -> B
- 1101111 -> J
- 0110111, 0010111 -> U
- 0110011 -> NONE
REQ-006 SHALL set ig_en=1 when the registered ig_sel is not NONE and inst_valid_out=1, and ig_en=0 otherwise.
REQ-007 SHALL, for any other opcode with inst_valid_in=1, load ig_sel=NONE, ig_en=0, illegal=1.
REQ-008 SHALL define a bubble as inst_out=32'h0000_0013 (NOP), inst_valid_out=0, ig_sel=NONE, ig_en=0, illegal=0.
REQ-009 SHALL load a bubble, not inst_in, whenever inst_valid_in=0 in RUN without stall or flush.
REQ-010 SHALL implement FSM states INIT, RUN, HOLD.
REQ-011 SHALL stay in INIT for exactly 2 cycles after rst deasserts, then go to RUN; in INIT:
- registers hold a bubble
- inputs are ignored
- init_done=0
- stall_cnt does not count
REQ-012 SHALL, in RUN, apply this per-cycle priority: flush > stall > load.
- flush: load a bubble; next state RUN.
- stall: keep all registers; next state HOLD.
- otherwise: load inst_in and its decode.
REQ-013 SHALL, in HOLD, keep all output registers unchanged while stall=1 and flush=0.
- stall=0 and flush=0: load inst_in and go to RUN in the same cycle.
- flush=1: load a bubble and go to RUN, regardless of stall.
REQ-014 SHALL increment stall_cnt by 1 in every RUN or HOLD cycle with stall=1 and flush=0, saturating at 8'hFF with no wrap.
REQ-015 SHALL hold init_done=1 in RUN and HOLD.
REQ-016 SHALL ignore flush and stall in INIT; simultaneous flush+stall+valid in RUN gives a bubble, and stall_cnt does not increment.
REQ-017 SHALL abort any state when rst is asserted mid-operation, with reset taking effect at the next clk edge.

Reset
REQ-018 SHALL, on rst=1 at a clk edge, set:
- state=INIT, with the INIT counter at 0
- inst_out=32'h0000_0013, inst_valid_out=0
- ig_sel=NONE, ig_en=0, illegal=0
- stall_cnt=0, init_done=0
REQ-019 SHALL have no asynchronous reset path.

Verification
REQ-020 Start-up: release rst, drive valid LUI 32'h12345037 every cycle.
- Cycles 1-2 after release: bubble, init_done=0.
- Cycle 3: init_done=1; cycle 4: inst_out=32'h12345037, ig_sel=U, ig_en=1.
REQ-021 Format sweep: in RUN, feed one each of LW, SW, BEQ, JAL, AUIPC, ADD, and opcode 7'b1111111.
- One cycle later, ig_sel=I,S,B,J,U,NONE,NONE respectively.
- illegal=1 only for 7'b1111111.
- ig_in equals inst_out[31:7] for every instruction.
REQ-022 Stall: load ADDI, then hold stall=1 for 3 cycles while inst_in changes.
- Outputs stay on the ADDI for 3 cycles and stall_cnt=3.
- The first cycle after stall drops loads the new inst_in.
REQ-023 Flush priority: in HOLD, assert flush=1 and stall=1 together with a valid BEQ.
- Next cycle: bubble, state RUN, stall_cnt unchanged.
REQ-024 Saturation and reset: hold stall=1 for 300 cycles.
- stall_cnt=8'hFF with no wrap.
- Then assert rst for 1 cycle mid-HOLD: next cycle all outputs equal the REQ-018 values.
